pc_3gpp_enc_ctrl_seq: RTL
=========================

PC_3GPP_ENC_CTRL_SEQ -- requirements
Module: pc_3gpp_enc_ctrl_seq

Interface
REQ-001 SHALL have parameter pN_LOG2_MAX, default 10, meaning the log2 of the largest supported code length (legal 3..12).
REQ-002 SHALL have parameter pKERN_CYCLES, default 2, meaning the cycles per 8x8 kernel pass (legal 1..4).
REQ-003 SHALL have ports: iclk  in  1  clock; ireset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: isclr  in  1  sync clear; iclkena  in  1  clock enable.
REQ-005 SHALL have ports: istart  in  1  start request; ilog2n  in  4  log2 code length, sampled at start; ordy  out  1  idle, start accepted.
REQ-006 SHALL have ports: ibuf_in_rdy, ibuf_out_rdy  in  1 each  input/output buffers ready; istage_ack  in  1  datapath combine-stage complete.
REQ-007 SHALL have ports: okern_en  out  1; okern_phase  out  2; ocomb8_en  out  1; ocomb8_phase  out  1; ocomb_en  out  1; ostage  out  4  active stage (4..pN_LOG2_MAX); oblk_idx  out  pN_LOG2_MAX-3  current 8-bit block; obusy  out  1; odone  out  1  one-cycle pulse.

Function
REQ-008 SHALL implement states IDLE, WAIT_RDY, KERN, COMB8, COMB, DONE; all transitions and register updates are gated by iclkena.
REQ-009 IDLE: ordy=1; on istart, SHALL latch L = clamp(ilog2n, 3, pN_LOG2_MAX), clear the block index to 0, and go to WAIT_RDY.
REQ-010 WAIT_RDY: SHALL go to KERN when ibuf_in_rdy & ibuf_out_rdy; otherwise hold.
REQ-011 KERN: SHALL stay exactly pKERN_CYCLES cycles with okern_phase = 0..pKERN_CYCLES-1, then go to COMB8.
REQ-012 COMB8: SHALL stay exactly 2 cycles (ocomb8_phase 0,1). After the second cycle:
  - if L==3, go to DONE;
  - else if blk_idx[0]==0, increment blk_idx and go to KERN;
  - else go to COMB with stage=4.
REQ-013 COMB: SHALL hold until istage_ack. On ack:
  - if stage==L, go to DONE;
  - else if blk_idx[stage-3]==1, increment stage and stay in COMB;
  - else increment blk_idx and go to KERN.
REQ-014 DONE: SHALL last 1 cycle with odone=1, then go to WAIT_RDY if istart is high (relatching ilog2n), else IDLE.
REQ-015 Outputs SHALL be Moore, registered from the next state, so each output is valid in the same cycle its state is active.
REQ-016 Combinational outputs: okern_en=KERN; ocomb8_en=COMB8; ocomb_en=COMB; obusy = not IDLE; ostage=0 outside COMB; oblk_idx holds its value between transitions.
REQ-017 Control flow:
  - istart SHALL be ignored outside IDLE and DONE.
  - istage_ack SHALL be ignored outside COMB.
  - ibuf_*_rdy SHALL be ignored outside WAIT_RDY.
REQ-018 Per codeword, the block SHALL execute exactly 2^(L-3) KERN passes and exactly 2^(L-3)-1 acked COMB steps.
REQ-019 Block-index width SHALL be pN_LOG2_MAX-3 bits; it never wraps within a codeword, since its last value is all-ones for the active L.

Reset
REQ-020 ireset SHALL asynchronously force IDLE, all counters to 0, all outputs 0, and ordy=1 on the first registered cycle after release.
REQ-021 isclr SHALL have the same effect synchronously, SHALL win over istart and iclkena, and SHALL abort any codeword in progress without an odone pulse.

Structure
REQ-022 The state enum, the output-word field positions, and the constants KERN_LOG2=3 and COMB8_CYCLES=2 SHALL live in the shared package pc_3gpp_enc_pkg.
REQ-023 A single sub-module, pc_3gpp_enc_stage_cnt, SHALL hold the block-index/stage counters and the continue-or-advance decision of REQ-012/REQ-013; the FSM stays in the top.

Verification
REQ-024 Test 1: L=3, buffers ready, pKERN_CYCLES=2, istart 1 cycle -> WAIT_RDY 1, KERN 2, COMB8 2, odone at cycle 6, then ordy.
REQ-025 Test 2: ilog2n=4, ack tied 1 -> KERN/COMB8 run for blk 0 then blk 1, one COMB with ostage=4, then odone; exactly 2 KERN passes.
REQ-026 Test 3: ilog2n=10, ack delayed 3 cycles -> 128 KERN passes and 127 COMB acks; ostage=10 seen exactly once; oblk_idx=127 at DONE.
REQ-027 Test 4: ilog2n=15 with pN_LOG2_MAX=10 -> clamped to 10; ilog2n=1 -> clamped to 3 (Test 1 timing).
REQ-028 Test 5: isclr asserted in COMB with ostage=6 -> IDLE next cycle, outputs 0, no odone; a following start runs normally.
REQ-029 Test 6: iclkena low for 5 cycles during KERN -> state, okern_phase and outputs frozen; total cycle count grows by exactly 5.

Source files
------------

// File: rtl/pc_3gpp_enc_pkg.sv
// pc_3gpp_enc_pkg: shared states, output-word layout and helpers for the polar encoder sequencer
package pc_3gpp_enc_pkg;

   localparam int KERN_LOG2    = 3;
   localparam int COMB8_CYCLES = 2;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_WAIT_RDY = 3'd1;
   localparam state_t S_KERN     = 3'd2;
   localparam state_t S_COMB8    = 3'd3;
   localparam state_t S_COMB     = 3'd4;
   localparam state_t S_DONE     = 3'd5;

   localparam int OW_RDY   = 0;
   localparam int OW_BUSY  = 1;
   localparam int OW_KERN  = 2;
   localparam int OW_COMB8 = 3;
   localparam int OW_COMB  = 4;
   localparam int OW_DONE  = 5;
   localparam int OW_W     = 6;

   // Moore decode of a state into the registered output word
   function automatic logic [OW_W-1:0] out_word(input state_t s);
      logic [OW_W-1:0] w;
      w           = '0;
      w[OW_RDY]   = s == S_IDLE;
      w[OW_BUSY]  = s != S_IDLE;
      w[OW_KERN]  = s == S_KERN;
      w[OW_COMB8] = s == S_COMB8;
      w[OW_COMB]  = s == S_COMB;
      w[OW_DONE]  = s == S_DONE;
      return w;
   endfunction

   // code length is never shorter than one 8x8 kernel nor longer than the build supports
   function automatic logic [3:0] clamp_log2(input logic [3:0] x, input int unsigned mx);
      return (x < 4'(KERN_LOG2)) ? 4'(KERN_LOG2) : ({28'd0, x} > mx) ? 4'(mx) : x;
   endfunction

endpackage

// File: rtl/pc_3gpp_enc_ctrl_seq_if.sv
// pc_3gpp_enc_ctrl_seq_if: start/buffer/ack handshake and sequencing outputs of the encoder control
interface pc_3gpp_enc_ctrl_seq_if import pc_3gpp_enc_pkg::*; #(
   parameter int pN_LOG2_MAX = 10
);
   localparam int BW = (pN_LOG2_MAX > KERN_LOG2) ? pN_LOG2_MAX - KERN_LOG2 : 1;

   logic          istart;
   logic [3:0]    ilog2n;
   logic          ordy;
   logic          ibuf_in_rdy;
   logic          ibuf_out_rdy;
   logic          istage_ack;
   logic          okern_en;
   logic [1:0]    okern_phase;
   logic          ocomb8_en;
   logic          ocomb8_phase;
   logic          ocomb_en;
   logic [3:0]    ostage;
   logic [BW-1:0] oblk_idx;
   logic          obusy;
   logic          odone;

   modport master (
      output istart, ilog2n, ibuf_in_rdy, ibuf_out_rdy, istage_ack,
      input  ordy, okern_en, okern_phase, ocomb8_en, ocomb8_phase, ocomb_en, ostage, oblk_idx, obusy, odone
   );

   modport slave (
      input  istart, ilog2n, ibuf_in_rdy, ibuf_out_rdy, istage_ack,
      output ordy, okern_en, okern_phase, ocomb8_en, ocomb8_phase, ocomb_en, ostage, oblk_idx, obusy, odone
   );

endinterface

// File: rtl/pc_3gpp_enc_stage_cnt.sv
// pc_3gpp_enc_stage_cnt: block-index/stage counters and the continue-or-advance decision
module pc_3gpp_enc_stage_cnt import pc_3gpp_enc_pkg::*; #(
   parameter int pBW = 7
) (
   input  logic           iclk,
   input  logic           ireset,
   input  logic           isclr,
   input  logic           iclkena,
   input  logic           iload,
   input  logic [3:0]     il,
   input  logic           ic8_end,
   input  logic           iack,
   output logic           olast8,
   output logic           obit0,
   output logic           ofin,
   output logic           ostay,
   output logic [pBW-1:0] oblk,
   output logic [3:0]     ostage
);

   logic [3:0]     l;
   logic [pBW-1:0] sh;

   // a block whose bit at the current stage is set has a finished sibling, so combining continues upward
   assign sh     = oblk >> (ostage - 4'(KERN_LOG2));
   assign olast8 = l == 4'(KERN_LOG2);
   assign obit0  = oblk[0];
   assign ofin   = ostage == l;
   assign ostay  = sh[0];

   // latch L on start, step the block index into the next kernel or the stage up the combine tree
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         l      <= '0;
         oblk   <= '0;
         ostage <= '0;
      end else if (isclr) begin
         l      <= '0;
         oblk   <= '0;
         ostage <= '0;
      end else if (iclkena) begin
         if (iload) begin
            l      <= il;
            oblk   <= '0;
            ostage <= '0;
         end else if (ic8_end && !olast8) begin
            if (obit0) ostage <= 4'(KERN_LOG2 + 1);
            else oblk <= oblk + 1'b1;
         end else if (iack) begin
            ostage <= (!ofin && ostay) ? ostage + 4'd1 : 4'd0;
            if (!ofin && !ostay) oblk <= oblk + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_3gpp_enc_ctrl_seq.sv
// pc_3gpp_enc_ctrl_seq: sequences 8x8 kernel passes and combine stages of a polar encoder codeword
module pc_3gpp_enc_ctrl_seq import pc_3gpp_enc_pkg::*; #(
   parameter int pN_LOG2_MAX  = 10,
   parameter int pKERN_CYCLES = 2
) (
   input logic                   iclk,
   input logic                   ireset,
   input logic                   isclr,
   input logic                   iclkena,
   pc_3gpp_enc_ctrl_seq_if.slave bus
);

   localparam int BW = (pN_LOG2_MAX > KERN_LOG2) ? pN_LOG2_MAX - KERN_LOG2 : 1;

   state_t          state;
   state_t          nxt;
   logic [1:0]      kph;
   logic            c8ph;
   logic [OW_W-1:0] ow;
   logic            last8, bit0, fin, stay;
   logic            kern_last, c8_last, load, c8_end, ack;
   logic [BW-1:0]   blk;
   logic [3:0]      stage;

   assign kern_last = kph == 2'(pKERN_CYCLES - 1);
   assign c8_last   = c8ph == 1'(COMB8_CYCLES - 1);
   assign load      = bus.istart && (state == S_IDLE || state == S_DONE);
   assign c8_end    = state == S_COMB8 && c8_last;
   assign ack       = state == S_COMB && bus.istage_ack;

   pc_3gpp_enc_stage_cnt #(.pBW(BW)) u_cnt (
      .iclk    (iclk),
      .ireset  (ireset),
      .isclr   (isclr),
      .iclkena (iclkena),
      .iload   (load),
      .il      (clamp_log2(bus.ilog2n, pN_LOG2_MAX)),
      .ic8_end (c8_end),
      .iack    (ack),
      .olast8  (last8),
      .obit0   (bit0),
      .ofin    (fin),
      .ostay   (stay),
      .oblk    (blk),
      .ostage  (stage)
   );

   // next-state selection; each state only looks at the inputs it owns
   always_comb begin
      case (state)
         S_IDLE, S_DONE: nxt = bus.istart ? S_WAIT_RDY : S_IDLE;
         S_WAIT_RDY:     nxt = (bus.ibuf_in_rdy && bus.ibuf_out_rdy) ? S_KERN : S_WAIT_RDY;
         S_KERN:         nxt = kern_last ? S_COMB8 : S_KERN;
         S_COMB8:        nxt = !c8_last ? S_COMB8 : last8 ? S_DONE : bit0 ? S_COMB : S_KERN;
         S_COMB:         nxt = !bus.istage_ack ? S_COMB : fin ? S_DONE : stay ? S_COMB : S_KERN;
         default:        nxt = S_IDLE;
      endcase
   end

   // state, phase counters and outputs all registered from the next state so they line up with it
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state <= S_IDLE;
         kph   <= '0;
         c8ph  <= 1'b0;
         ow    <= out_word(S_IDLE);
      end else if (isclr) begin
         state <= S_IDLE;
         kph   <= '0;
         c8ph  <= 1'b0;
         ow    <= out_word(S_IDLE);
      end else if (iclkena) begin
         state <= nxt;
         kph   <= (state == S_KERN && nxt == S_KERN) ? kph + 2'd1 : 2'd0;
         c8ph  <= state == S_COMB8 && nxt == S_COMB8;
         ow    <= out_word(nxt);
      end
   end

   assign bus.ordy         = ow[OW_RDY];
   assign bus.obusy        = ow[OW_BUSY];
   assign bus.okern_en     = ow[OW_KERN];
   assign bus.ocomb8_en    = ow[OW_COMB8];
   assign bus.ocomb_en     = ow[OW_COMB];
   assign bus.odone        = ow[OW_DONE];
   assign bus.okern_phase  = kph;
   assign bus.ocomb8_phase = c8ph;
   assign bus.ostage       = stage;
   assign bus.oblk_idx     = blk;

endmodule
